// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared flush FSM states, width helpers and tree pseudo-LRU functions
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WB
    } flush_state_t;

    localparam int PLRU_MAX_W = 7;
    localparam int WAY_MAX_W  = 3;

    function automatic int idx_width(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int plru_width(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 points the victim right.
    function automatic logic [WAY_MAX_W-1:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                                         input int levels);
        logic [2:0] node;
        logic [2:0] way;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_MAX_W; l++) begin
            if (l < levels) begin
                way  = {way[1:0], bits[node]};
                node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
            end
        end
        return way;
    endfunction

    function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] bits,
                                                          input logic [WAY_MAX_W-1:0] way,
                                                          input int levels);
        logic [PLRU_MAX_W-1:0] nb;
        logic [2:0]            node;
        logic [2:0]            path;
        logic                  dir;
        nb   = bits;
        node = '0;
        path = way << (WAY_MAX_W - levels);
        for (int l = 0; l < WAY_MAX_W; l++) begin
            if (l < levels) begin
                dir      = path[2];
                path     = path << 1;
                nb[node] = ~dir;
                node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
            end
        end
        return nb;
    endfunction

endpackage

// File: rtl/dcache_plru.sv
// rtl/dcache_plru.sv - per-set tree pseudo-LRU victim pick and most-recent update
module dcache_plru
    import dcache_pkg::*;
#(
    parameter  int WAYS   = 2,
    localparam int PLRU_W = plru_width(WAYS),
    localparam int WAY_W  = way_width(WAYS)
) (
    input  logic [PLRU_W-1:0] bits,
    input  logic [WAY_W-1:0]  way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] bits_next
);

    localparam int LEVELS = (WAYS > 1) ? $clog2(WAYS) : 0;

    // Kept as separate assigns: victim feeds the accessed way, which feeds the update.
    assign victim    = WAY_W'(plru_victim(PLRU_MAX_W'(bits), LEVELS));
    assign bits_next = PLRU_W'(plru_update(PLRU_MAX_W'(bits), WAY_MAX_W'(way), LEVELS));

endmodule

// File: rtl/dcache_sram_assoc.sv
// rtl/dcache_sram_assoc.sv - set-associative line store with pseudo-LRU replacement and flush engine
module dcache_sram_assoc
    import dcache_pkg::*;
#(
    parameter  int SETS   = 16,
    parameter  int WAYS   = 2,
    parameter  int TAG_W  = 23,
    parameter  int LINE_W = 256,
    localparam int IDX_W  = idx_width(SETS),
    localparam int WAY_W  = way_width(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic              dirty_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              flush_i,
    input  logic              wb_ready_i,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              dirty_o,
    output logic              busy_o,
    output logic              wb_valid_o,
    output logic [IDX_W-1:0]  wb_addr_o
);

    localparam int               PLRU_W   = plru_width(WAYS);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid    [SETS];
    logic [WAYS-1:0]   dirty    [SETS];
    logic [PLRU_W-1:0] lru      [SETS];

    flush_state_t      state, state_n;
    logic [IDX_W-1:0]  ptr_set, ptr_set_n;
    logic [WAY_W-1:0]  ptr_way, ptr_way_n;

    logic [WAYS-1:0]   match;
    logic              hit_any, has_inv;
    logic [WAY_W-1:0]  hit_way, inv_way, victim, acc_way, rd_way;
    logic [IDX_W-1:0]  rd_set;
    logic [PLRU_W-1:0] lru_next;
    logic              busy, accept, do_write, do_lru;
    logic              entry_dirty, last_entry, advance, clear_entry, clear_lru;

    // Scanning downward leaves the lowest-index match / invalid way as the winner.
    always_comb begin
        match   = '0;
        has_inv = 1'b0;
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match[w] = valid[addr_i][w] && (tag_mem[addr_i][w] == tag_i);
            if (match[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid[addr_i][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign hit_any  = |match;
    assign acc_way  = hit_any ? hit_way : (has_inv ? inv_way : victim);

    dcache_plru #(
        .WAYS (WAYS)
    ) u_plru (
        .bits      (lru[addr_i]),
        .way       (acc_way),
        .victim    (victim),
        .bits_next (lru_next)
    );

    assign busy     = (state != ST_IDLE);
    assign accept   = enable_i && !busy;
    assign do_write = accept && write_i;
    assign do_lru   = accept && (hit_any || write_i);

    // While flushing, the read port follows the scan pointer so the writeback payload is visible.
    assign rd_set  = busy ? ptr_set : addr_i;
    assign rd_way  = busy ? ptr_way : acc_way;

    assign hit_o     = accept && hit_any;
    assign way_o     = rd_way;
    assign tag_o     = tag_mem[rd_set][rd_way];
    assign data_o    = data_mem[rd_set][rd_way];
    assign dirty_o   = valid[rd_set][rd_way] && dirty[rd_set][rd_way];
    assign busy_o    = busy;
    assign wb_addr_o = ptr_set;

    assign entry_dirty = valid[ptr_set][ptr_way] && dirty[ptr_set][ptr_way];
    assign last_entry  = (ptr_set == LAST_SET) && (ptr_way == LAST_WAY);

    always_comb begin
        state_n     = state;
        ptr_set_n   = ptr_set;
        ptr_way_n   = ptr_way;
        advance     = 1'b0;
        clear_entry = 1'b0;
        clear_lru   = 1'b0;
        wb_valid_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_i) begin
                    state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (entry_dirty) begin
                    state_n = ST_WB;
                end else begin
                    clear_entry = 1'b1;
                    advance     = 1'b1;
                end
            end
            ST_WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    clear_entry = 1'b1;
                    advance     = 1'b1;
                    state_n     = ST_SCAN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (advance) begin
            if (last_entry) begin
                state_n   = ST_IDLE;
                clear_lru = 1'b1;
                ptr_set_n = '0;
                ptr_way_n = '0;
            end else if (ptr_way == LAST_WAY) begin
                ptr_way_n = '0;
                ptr_set_n = ptr_set + 1'b1;
            end else begin
                ptr_way_n = ptr_way + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            ptr_set <= '0;
            ptr_way <= '0;
        end else begin
            state   <= state_n;
            ptr_set <= ptr_set_n;
            ptr_way <= ptr_way_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                lru[s]   <= '0;
            end
        end else begin
            if (do_write) begin
                valid[addr_i][acc_way] <= 1'b1;
                dirty[addr_i][acc_way] <= dirty_i;
            end
            if (clear_entry) begin
                valid[ptr_set][ptr_way] <= 1'b0;
                dirty[ptr_set][ptr_way] <= 1'b0;
            end
            if (clear_lru) begin
                for (int s = 0; s < SETS; s++) begin
                    lru[s] <= '0;
                end
            end else if (do_lru) begin
                lru[addr_i] <= lru_next;
            end
        end
    end

    // Tag and data storage carry no reset; entries are meaningless until their valid bit is set.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            tag_mem[addr_i][acc_way]  <= tag_i;
            data_mem[addr_i][acc_way] <= data_i;
        end
    end

endmodule

// File: tb/tb_dcache_sram_assoc.sv
// tb/tb_dcache_sram_assoc.sv - directed vector and sequence bench for dcache_sram_assoc
module tb_dcache_sram_assoc;

    localparam int SETS   = 16;
    localparam int WAYS   = 2;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n, en, wr, dty, flush, wb_ready;
    logic [3:0]        addr;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
    logic              hit, dirty_out, busy, wb_valid;
    logic [0:0]        way;
    logic [TAG_W-1:0]  tag_out;
    logic [LINE_W-1:0] data_out;
    logic [3:0]        wb_addr;

    always #5 clk = ~clk;

    dcache_sram_assoc #(
        .SETS   (SETS),
        .WAYS   (WAYS),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (en),
        .write_i    (wr),
        .dirty_i    (dty),
        .addr_i     (addr),
        .tag_i      (tag),
        .data_i     (data),
        .flush_i    (flush),
        .wb_ready_i (wb_ready),
        .hit_o      (hit),
        .way_o      (way),
        .tag_o      (tag_out),
        .data_o     (data_out),
        .dirty_o    (dirty_out),
        .busy_o     (busy),
        .wb_valid_o (wb_valid),
        .wb_addr_o  (wb_addr)
    );

    typedef struct {
        logic              en, wr, dty;
        logic [3:0]        addr;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
        logic              hit, way, dirty;
        logic              ct;
        logic [TAG_W-1:0]  etag;
        logic              cd;
        logic [LINE_W-1:0] edata;
    } vec_t;

    vec_t              vecs[$];
    int                n_pass  = 0;
    int                n_total = 0;
    int                vec_no  = 0;
    logic [LINE_W-1:0] da, db, dc, dd, dz;
    logic [3:0]        exp_set  [2];
    logic [TAG_W-1:0]  exp_tag  [2];
    logic [LINE_W-1:0] exp_data [2];

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic e, input logic w, input logic d, input logic [3:0] a,
                                input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] dat,
                                input logic h, input logic wy, input logic dy,
                                input logic ct, input logic [TAG_W-1:0] et,
                                input logic cd, input logic [LINE_W-1:0] ed);
        vec_t v;
        v.en = e; v.wr = w; v.dty = d; v.addr = a; v.tag = t; v.data = dat;
        v.hit = h; v.way = wy; v.dirty = dy; v.ct = ct; v.etag = et; v.cd = cd; v.edata = ed;
        return v;
    endfunction

    // Entered and left at one time unit after a rising edge.
    task automatic apply_all();
        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; wr = vecs[i].wr; dty = vecs[i].dty;
            addr = vecs[i].addr; tag = vecs[i].tag; data = vecs[i].data;
            #3;
            chk($sformatf("v%0d_hit", vec_no), LINE_W'(hit), LINE_W'(vecs[i].hit));
            chk($sformatf("v%0d_way", vec_no), LINE_W'(way), LINE_W'(vecs[i].way));
            chk($sformatf("v%0d_dirty", vec_no), LINE_W'(dirty_out), LINE_W'(vecs[i].dirty));
            if (vecs[i].ct) chk($sformatf("v%0d_tag", vec_no), LINE_W'(tag_out), LINE_W'(vecs[i].etag));
            if (vecs[i].cd) chk($sformatf("v%0d_data", vec_no), data_out, vecs[i].edata);
            @(posedge clk); #1;
            en = 1'b0; wr = 1'b0; dty = 1'b0;
            vec_no++;
        end
        vecs.delete();
    endtask

    task automatic do_flush(input string nm, input int exp_busy, input int exp_lines, input int poke_at);
        int                busy_cnt = 0;
        int                wbc      = 0;
        int                lines    = 0;
        logic              done     = 1'b0;
        logic [3:0]        s_addr   = '0;
        logic [TAG_W-1:0]  s_tag    = '0;
        logic [LINE_W-1:0] s_data   = '0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (!busy) begin
                done = 1'b1;
            end else begin
                busy_cnt++;
                en = 1'b0; wr = 1'b0;
                if (busy_cnt == poke_at) begin
                    en = 1'b1; wr = 1'b1; dty = 1'b0; addr = 4'd2; tag = 23'h77; data = dz;
                    #1;
                    chk({nm, "_poke_hit"}, LINE_W'(hit), '0);
                end
                if (wb_valid) begin
                    wbc++;
                    if (wbc == 1) begin
                        s_addr = wb_addr; s_tag = tag_out; s_data = data_out;
                        if (lines < exp_lines) begin
                            chk($sformatf("%s_wb%0d_addr", nm, lines), LINE_W'(wb_addr), LINE_W'(exp_set[lines]));
                            chk($sformatf("%s_wb%0d_tag", nm, lines), LINE_W'(tag_out), LINE_W'(exp_tag[lines]));
                            chk($sformatf("%s_wb%0d_data", nm, lines), data_out, exp_data[lines]);
                        end else begin
                            chk({nm, "_extra_wb"}, LINE_W'(lines + 1), LINE_W'(exp_lines));
                        end
                    end else begin
                        chk($sformatf("%s_wb%0d_addr_hold", nm, lines), LINE_W'(wb_addr), LINE_W'(s_addr));
                        chk($sformatf("%s_wb%0d_tag_hold", nm, lines), LINE_W'(tag_out), LINE_W'(s_tag));
                        chk($sformatf("%s_wb%0d_data_hold", nm, lines), data_out, s_data);
                    end
                    if (wbc == 4) begin
                        wb_ready = 1'b1;
                        lines++;
                        wbc = 0;
                    end else begin
                        wb_ready = 1'b0;
                    end
                end else begin
                    wb_ready = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        en = 1'b0; wr = 1'b0; wb_ready = 1'b0;
        chk({nm, "_done"}, LINE_W'(done), LINE_W'(1));
        chk({nm, "_busy_cycles"}, LINE_W'(busy_cnt), LINE_W'(exp_busy));
        chk({nm, "_wb_lines"}, LINE_W'(lines), LINE_W'(exp_lines));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        da = {8{32'hAAAA_0001}};
        db = {8{32'hBBBB_0002}};
        dc = {8{32'hCCCC_0003}};
        dd = {8{32'hDDDD_0004}};
        dz = {8{32'h7777_0005}};
        exp_set[0] = 4'd5;   exp_tag[0] = 23'h10; exp_data[0] = da;
        exp_set[1] = 4'd9;   exp_tag[1] = 23'h55; exp_data[1] = dd;

        rst_n = 1'b0; en = 1'b1; wr = 1'b0; dty = 1'b0; flush = 1'b0; wb_ready = 1'b0;
        addr = 4'd3; tag = 23'h1A; data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", LINE_W'(hit), '0);
        chk("rst_dirty", LINE_W'(dirty_out), '0);
        chk("rst_busy", LINE_W'(busy), '0);
        chk("rst_wb_valid", LINE_W'(wb_valid), '0);
        rst_n = 1'b1; en = 1'b0;
        @(posedge clk); #1;

        //            en    wr    dty   set   tag     data  hit   way   dirty ct    etag    cd    edata
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd3, 23'h1A, '0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd5, 23'h10, da, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd5, 23'h20, db, 1'b0, 1'b1, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd5, 23'h10, '0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h10, 1'b1, da));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd5, 23'h30, dc, 1'b0, 1'b1, 1'b0, 1'b1, 23'h20, 1'b1, db));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd5, 23'h30, '0, 1'b1, 1'b1, 1'b0, 1'b1, 23'h30, 1'b1, dc));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'd5, 23'h10, da, 1'b1, 1'b0, 1'b0, 1'b1, 23'h10, 1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd5, 23'h30, '0, 1'b1, 1'b1, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd5, 23'h40, '0, 1'b0, 1'b0, 1'b1, 1'b1, 23'h10, 1'b1, da));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'd9, 23'h55, dd, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd9, 23'h55, '0, 1'b1, 1'b0, 1'b1, 1'b1, 23'h55, 1'b1, dd));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'd5, 23'h10, '0, 1'b0, 1'b0, 1'b1, 1'b1, 23'h10, 1'b0, '0));
        apply_all();

        do_flush("flush_dirty", 40, 2, -1);

        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd5, 23'h10, '0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd5, 23'h30, '0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd9, 23'h55, '0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        apply_all();

        do_flush("flush_poke", 32, 0, 20);
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd2, 23'h77, '0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'd1, 23'h11, da, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        apply_all();

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int c = 0; c < 50 && !wb_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("rstwb_reached", LINE_W'(wb_valid), LINE_W'(1));
        chk("rstwb_addr", LINE_W'(wb_addr), LINE_W'(4'd1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstwb_busy", LINE_W'(busy), '0);
        chk("rstwb_wb_valid", LINE_W'(wb_valid), '0);
        chk("rstwb_dirty", LINE_W'(dirty_out), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 23'h11, '0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd1, 23'h12, db, 1'b0, 1'b0, 1'b0, 1'b0, 23'h0,  1'b0, '0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 23'h12, '0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h12, 1'b1, db));
        apply_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_sram_assoc.md
DCACHE_SRAM_ASSOC -- requirements
Module: dcache_sram_assoc

Interface
REQ-001 SHALL have parameter SETS, default 16, number of sets (power of 2, 2..256); IDX_W = clog2(SETS).
REQ-002 SHALL have parameter WAYS, default 2, associativity (power of 2, 1..8).
REQ-003 SHALL have parameter TAG_W, default 23, tag width; valid/dirty kept outside tag.
REQ-004 SHALL have parameter LINE_W, default 256, line width in bits.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable_i  input  1  access request this cycle.
REQ-008 SHALL have port write_i  input  1  access is a write (hit update or victim fill).
REQ-009 SHALL have port dirty_i  input  1  dirty value stored on write.
REQ-010 SHALL have port addr_i  input  IDX_W  set index.
REQ-011 SHALL have port tag_i  input  TAG_W  lookup/store tag.
REQ-012 SHALL have port data_i  input  LINE_W  line to store.
REQ-013 SHALL have port flush_i  input  1  start flush (write back and invalidate all).
REQ-014 SHALL have port wb_ready_i  input  1  flush writeback accepted.
REQ-015 SHALL have port hit_o  output  1  valid tag match in addressed set.
REQ-016 SHALL have port way_o  output  clog2(WAYS) (min 1)  hit way, else victim way.
REQ-017 SHALL have port tag_o / data_o / dirty_o  output  TAG_W / LINE_W / 1  selected entry (dirty_o = valid AND dirty).
REQ-018 SHALL have port busy_o, wb_valid_o  output  1 each  flush in progress / writeback line presented.
REQ-019 SHALL have port wb_addr_o  output  IDX_W  set of line presented for writeback.

Function
REQ-020 SHALL evaluate lookup combinationally: hit_o = enable_i AND NOT busy AND some way valid with tag equal to tag_i.
REQ-021 SHALL select way: lowest-index hit way; on miss, lowest-index invalid way; else pseudo-LRU way; tag_o/data_o/dirty_o show that way.
REQ-022 SHALL, on a clock edge with enable_i, write_i, NOT busy: store data_i, tag_i, valid=1, dirty=dirty_i into way_o of addr_i.
REQ-023 SHALL keep tree pseudo-LRU state (WAYS-1 bits per set; 1 bit for WAYS=2; none for WAYS=1), updated on every accepted hit or write to mark way_o most recent.
REQ-024 SHALL make read-after-write visible on the cycle after the write edge; same-cycle reads return pre-write contents.
REQ-025 SHALL ignore enable_i (no state change, hit_o=0) while busy_o=1.
REQ-026 SHALL implement flush FSM IDLE -> SCAN -> (WB <-> SCAN) -> IDLE, entry pointer (set, way) from (0,0), way-fastest.
REQ-027 SHALL in IDLE with flush_i=1 perform any same-cycle access, then enter SCAN; busy_o rises next cycle; flush_i ignored while busy.
REQ-028 SHALL in SCAN clear valid of a clean/invalid entry and advance one entry per cycle; a valid dirty entry enters WB.
REQ-029 SHALL in WB hold wb_valid_o=1, wb_addr_o, tag_o, data_o stable until wb_ready_i; on that edge clear valid and dirty, advance, return to SCAN.
REQ-030 SHALL return to IDLE after the last entry (SETS*WAYS-1), clear all LRU bits, drop busy_o; all-clean flush takes SETS*WAYS busy cycles.

Reset
REQ-031 SHALL on rst_ni low immediately clear all valid, dirty, LRU bits, FSM to IDLE, pointer to (0,0); busy_o=0, wb_valid_o=0, hit_o=0, dirty_o=0, including mid-flush.
REQ-032 SHALL not reset tag/data arrays; contents are don't-care while invalid.

Structure
REQ-033 SHALL place flush FSM state enum, clog2-derived width constants and PLRU helper functions in shared package dcache_pkg.
REQ-034 SHALL instantiate sub-module dcache_plru (per-set victim selection and update from current bits and accessed way).

Verification (SETS=16, WAYS=2)
REQ-035 SHALL check: after reset, read set 3 tag 0x1A -> hit_o=0, dirty_o=0, way_o=0.
REQ-036 SHALL check: fill set 5 tag 0x10 data A, then tag 0x20 data B -> ways 0,1; read 0x10 -> hit, data A; fill 0x30 -> replaces way 1.
REQ-037 SHALL check: write hit set 5 tag 0x10 dirty_i=1, touch way 1, miss tag 0x40 -> way_o=0, tag_o=0x10, dirty_o=1.
REQ-038 SHALL check: flush with 2 dirty lines, wb_ready_i low 3 cycles each -> payload stable, busy 32+8 cycles, all lookups then miss.
REQ-039 SHALL check: write during busy_o=1 -> no array change; rst_ni low during WB -> busy_o, wb_valid_o 0 same cycle, all invalid.
